dual_issue_hazard_ctrl: RTL and testbench

Hazard and issue controller for the dual-issue 8-bit pipeline. It is the consumer of the ID/EX register contents: it compares destination and load state held in ID/EX against source registers of the pair being decoded in ID. It drives PC and IF/ID write enables, and per-slot bubble requests that zero slot control as it enters ID/EX. A SPLIT state serialises a bundle whose slot 2 depends on slot 1.

---
 rtl/dual_issue_hazard_ctrl_pkg.sv | 13 +
 rtl/dual_issue_hazard_ctrl_hazard_src_match.sv | 21 ++
 rtl/dual_issue_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_dual_issue_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_hazard_ctrl_pkg.sv
// rtl/dual_issue_hazard_ctrl_pkg.sv - shared state encoding and defaults for the dual-issue hazard controller
package dual_issue_hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_t;

  localparam int REG_X0     = 0;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/dual_issue_hazard_ctrl_hazard_src_match.sv
// rtl/dual_issue_hazard_ctrl_hazard_src_match.sv - one valid destination against up to two sources
module hazard_src_match
  import dual_issue_hazard_ctrl_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic          valid,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic          use_src2,
  output logic          match
);

  logic dst_real;

  // x0 is hardwired zero, so writing it never creates a dependency
  assign dst_real = (dst != AW'(REG_X0));
  assign match    = valid && dst_real && ((dst == src1) || (use_src2 && (dst == src2)));

endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// rtl/dual_issue_hazard_ctrl.sv - RUN/SPLIT issue controller; stall/split counters under HAZARD_STATS_EN
module dual_issue_hazard_ctrl
  import dual_issue_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_memread1,
  input  logic              ex_memread2,
  input  logic [REG_AW-1:0] ex_rd1,
  input  logic [REG_AW-1:0] ex_rd2,
  input  logic [REG_AW-1:0] id_rs1_1,
  input  logic [REG_AW-1:0] id_rs2_1,
  input  logic [REG_AW-1:0] id_rs1_2,
  input  logic [REG_AW-1:0] id_rs2_2,
  input  logic              id_use_rs2_1,
  input  logic              id_use_rs2_2,
  input  logic [REG_AW-1:0] id_rd1,
  input  logic              id_regwrite1,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              bubble1,
  output logic              bubble2,
  output logic              in_split,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  split_cnt
);

  state_t state, next_state;
  logic   lu1_a, lu1_b, lu2_a, lu2_b, dep;
  logic   lu1, lu2;
  logic   stall_inc, split_inc;

  hazard_src_match #(.AW(REG_AW)) u_lu1_a (
    .valid(ex_memread1), .dst(ex_rd1), .src1(id_rs1_1), .src2(id_rs2_1),
    .use_src2(id_use_rs2_1), .match(lu1_a)
  );
  hazard_src_match #(.AW(REG_AW)) u_lu1_b (
    .valid(ex_memread2), .dst(ex_rd2), .src1(id_rs1_1), .src2(id_rs2_1),
    .use_src2(id_use_rs2_1), .match(lu1_b)
  );
  hazard_src_match #(.AW(REG_AW)) u_lu2_a (
    .valid(ex_memread1), .dst(ex_rd1), .src1(id_rs1_2), .src2(id_rs2_2),
    .use_src2(id_use_rs2_2), .match(lu2_a)
  );
  hazard_src_match #(.AW(REG_AW)) u_lu2_b (
    .valid(ex_memread2), .dst(ex_rd2), .src1(id_rs1_2), .src2(id_rs2_2),
    .use_src2(id_use_rs2_2), .match(lu2_b)
  );
  hazard_src_match #(.AW(REG_AW)) u_dep (
    .valid(id_regwrite1), .dst(id_rd1), .src1(id_rs1_2), .src2(id_rs2_2),
    .use_src2(id_use_rs2_2), .match(dep)
  );

  assign lu1      = lu1_a | lu1_b;
  assign lu2      = lu2_a | lu2_b;
  assign in_split = (state == SPLIT);

  always_comb begin
    next_state = state;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble1    = 1'b0;
    bubble2    = 1'b0;
    stall_inc  = 1'b0;
    split_inc  = 1'b0;
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble1    = 1'b1;
      bubble2    = 1'b1;
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            bubble1 = 1'b1;
            bubble2 = 1'b1;
          end else if (lu1 || lu2) begin
            bubble1    = 1'b1;
            bubble2    = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
          end else if (dep) begin
            bubble2    = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            split_inc  = 1'b1;
            next_state = SPLIT;
          end
        end
        SPLIT: begin
          // slot 1 left on the previous cycle; only slot 2 is still pending
          bubble1 = 1'b1;
          if (flush) begin
            bubble2    = 1'b1;
            next_state = RUN;
          end else if (lu2) begin
            bubble2    = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
          end else begin
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= next_state;
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, split_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      split_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (split_inc && (split_q != '1)) split_q <= split_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign split_cnt = split_q;
`else
  logic unused_stats;
  assign unused_stats = stall_inc ^ split_inc;
  assign stall_cnt    = '0;
  assign split_cnt    = '0;
`endif

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// tb/tb_dual_issue_hazard_ctrl.sv - directed and randomized checks against a rule-level reference model
module tb_dual_issue_hazard_ctrl;

  localparam int AW      = 5;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, mr1, mr2, u21, u22, regw1;
  logic [AW-1:0] rd1, rd2, rs1_1, rs2_1, rs1_2, rs2_2, id_rd1;
  logic          pc_write, ifid_write, bubble1, bubble2, in_split;
  logic [CW-1:0] stall_cnt, split_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state: is slot 2 of the current pair still waiting to issue
  bit m_holding;
  int m_stalls, m_splits;
  bit e_pc, e_b1, e_b2, e_next_holding, e_stall, e_split;

  always #5 clk = ~clk;

  dual_issue_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_memread1(mr1), .ex_memread2(mr2), .ex_rd1(rd1), .ex_rd2(rd2),
    .id_rs1_1(rs1_1), .id_rs2_1(rs2_1), .id_rs1_2(rs1_2), .id_rs2_2(rs2_2),
    .id_use_rs2_1(u21), .id_use_rs2_2(u22), .id_rd1(id_rd1), .id_regwrite1(regw1),
    .pc_write(pc_write), .ifid_write(ifid_write), .bubble1(bubble1), .bubble2(bubble2),
    .in_split(in_split), .stall_cnt(stall_cnt), .split_cnt(split_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [AW-1:0] d, input logic [AW-1:0] s1,
                               input logic [AW-1:0] s2, input logic use2);
    return (d != 0) && ((d == s1) || (use2 && (d == s2)));
  endfunction

  task automatic model_eval();
    bit slot1_waits_load, slot2_waits_load, slot2_needs_slot1;
    slot1_waits_load  = (mr1 && reads(rd1, rs1_1, rs2_1, u21)) || (mr2 && reads(rd2, rs1_1, rs2_1, u21));
    slot2_waits_load  = (mr1 && reads(rd1, rs1_2, rs2_2, u22)) || (mr2 && reads(rd2, rs1_2, rs2_2, u22));
    slot2_needs_slot1 = regw1 && reads(id_rd1, rs1_2, rs2_2, u22);
    e_stall = 0; e_split = 0; e_next_holding = 0;
    if (!reset) begin
      m_holding = 0; m_stalls = 0; m_splits = 0;
      e_pc = 0; e_b1 = 1; e_b2 = 1;
    end else if (flush) begin
      e_pc = 1; e_b1 = 1; e_b2 = 1;
    end else if (!m_holding) begin
      if (slot1_waits_load || slot2_waits_load) begin
        e_pc = 0; e_b1 = 1; e_b2 = 1; e_stall = 1;
      end else if (slot2_needs_slot1) begin
        e_pc = 0; e_b1 = 0; e_b2 = 1; e_split = 1; e_next_holding = 1;
      end else begin
        e_pc = 1; e_b1 = 0; e_b2 = 0;
      end
    end else begin
      e_b1 = 1;
      e_pc = !slot2_waits_load;
      e_b2 = slot2_waits_load;
      e_stall = slot2_waits_load;
      e_next_holding = slot2_waits_load;
    end
  endtask

  // inputs are already applied; check half a cycle before the edge, then advance the model
  task automatic cycle();
    #1;
    model_eval();
    check("pc_write",   32'(pc_write),   32'(e_pc));
    check("ifid_write", 32'(ifid_write), 32'(e_pc));
    check("bubble1",    32'(bubble1),    32'(e_b1));
    check("bubble2",    32'(bubble2),    32'(e_b2));
    check("in_split",   32'(in_split),   32'(m_holding));
`ifdef HAZARD_STATS_EN
    check("stall_cnt",  32'(stall_cnt),  32'(m_stalls));
    check("split_cnt",  32'(split_cnt),  32'(m_splits));
`else
    check("stall_cnt",  32'(stall_cnt),  32'd0);
    check("split_cnt",  32'(split_cnt),  32'd0);
`endif
    @(posedge clk);
    if (reset) begin
      m_holding = e_next_holding;
      if (e_stall && m_stalls < CNT_MAX) m_stalls++;
      if (e_split && m_splits < CNT_MAX) m_splits++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; mr1 = 0; mr2 = 0; rd1 = 0; rd2 = 0;
    rs1_1 = 0; rs2_1 = 0; rs1_2 = 0; rs2_2 = 0;
    u21 = 0; u22 = 0; id_rd1 = 0; regw1 = 0;
  endtask

  task automatic set_split_pair();
    clear_inputs();
    regw1 = 1; id_rd1 = 5'd3; rs2_2 = 5'd3; u22 = 1;
  endtask

  initial begin
    m_holding = 0; m_stalls = 0; m_splits = 0;
    reset = 0;
    clear_inputs();
    @(negedge clk);
    cycle();
    reset = 1;
    cycle();

    // load-use on slot 2 through ex slot 1
    mr1 = 1; rd1 = 5'd5; rs1_2 = 5'd5;
    cycle();
    clear_inputs();
    cycle();

    // x0 destination and an rs2 field that is not a real source
    mr2 = 1; rd2 = 5'd0; rs1_1 = 5'd0;
    cycle();
    rd2 = 5'd7; rs2_1 = 5'd7; u21 = 0;
    cycle();

    // slot 2 depends on slot 1: split, then issue slot 2
    set_split_pair();
    cycle();
    rd1 = 5'd3;
    cycle();
    clear_inputs();
    cycle();

    // slot 1 is a load feeding slot 2: split, load-use hold, then issue
    set_split_pair();
    cycle();
    mr1 = 1; rd1 = 5'd3;
    cycle();
    mr1 = 0;
    cycle();
    clear_inputs();
    cycle();

    // flush beats load-use and dependency in RUN, and leaves SPLIT
    set_split_pair();
    mr1 = 1; rd1 = 5'd4; rs1_1 = 5'd4; flush = 1;
    cycle();
    set_split_pair();
    cycle();
    flush = 1;
    cycle();
    clear_inputs();
    cycle();

    // asynchronous reset while in SPLIT
    set_split_pair();
    cycle();
    reset = 0;
    cycle();
    reset = 1;
    clear_inputs();
    cycle();

    // saturation of the stall counter
    mr1 = 1; rd1 = 5'd9; rs1_1 = 5'd9;
    for (int i = 0; i < 300; i++) cycle();
    clear_inputs();
    cycle();

    // randomized pairs over a small register range to make hazards common
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) != 0);
      flush  = ($urandom_range(0, 9) == 0);
      mr1    = 1'($urandom_range(0, 1));
      mr2    = 1'($urandom_range(0, 1));
      rd1    = 5'($urandom_range(0, 3));
      rd2    = 5'($urandom_range(0, 3));
      rs1_1  = 5'($urandom_range(0, 3));
      rs2_1  = 5'($urandom_range(0, 3));
      rs1_2  = 5'($urandom_range(0, 3));
      rs2_2  = 5'($urandom_range(0, 3));
      u21    = 1'($urandom_range(0, 1));
      u22    = 1'($urandom_range(0, 1));
      id_rd1 = 5'($urandom_range(0, 3));
      regw1  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
